// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types.
//
// Contents:
//   forward_rs1_mux_t / forward_rs2_mux_t - legacy fixed forward selects, still used by the
//                                           old datapath.
//   fwd_tag_t        - one tracked post-EX stage {valid, rd, avail_cnt}. Its field widths match
//                      the default rv32i configuration (5-bit rd, LOAD_LAT=1).
//   FWD_SEL_REGFILE  - forward-select code meaning "use the regfile value".
//   fwd_stage_sel()  - forward-select code for tracked stage k.
package rv32i_types;

  localparam int unsigned RV_REG_ADDR_W = 5;
  localparam int unsigned RV_AVAIL_W    = 1;

  // Legacy per-source forward selects.
  typedef enum logic [1:0] {
    Rs1Regfile = 2'd0,
    Rs1ExMem   = 2'd1,
    Rs1MemWb   = 2'd2
  } forward_rs1_mux_t;

  typedef enum logic [1:0] {
    Rs2Regfile = 2'd0,
    Rs2ExMem   = 2'd1,
    Rs2MemWb   = 2'd2
  } forward_rs2_mux_t;

  typedef struct packed {
    logic                     valid;
    logic [RV_REG_ADDR_W-1:0] rd;
    logic [RV_AVAIL_W-1:0]    avail_cnt;
  } fwd_tag_t;

  localparam int unsigned FWD_SEL_REGFILE = 0;

  // Tracked stage k is encoded as k+1 so that 0 stays free for the regfile.
  function automatic int unsigned fwd_stage_sel(input int unsigned k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_src_match.sv
// Priority match of one source specifier against the tracked post-EX stages.
//
// Ports:
//   src        in   source register specifier
//   en         in   instruction in EX is valid
//   tag_valid  in   per-stage valid bits
//   tag_rd     in   per-stage destination specifiers
//   tag_busy   in   per-stage "load data not yet forwardable"
//   sel        out  0 = regfile, k+1 = forward from stage k (youngest match)
//   not_avail  out  youngest match is still waiting on load data
module fwd_src_match
  import rv32i_types::*;
#(
  parameter int unsigned FWD_DEPTH  = 3,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned SEL_W      = 2
) (
  input  logic [REG_ADDR_W-1:0]                src,
  input  logic                                 en,
  input  logic [FWD_DEPTH-1:0]                 tag_valid,
  input  logic [FWD_DEPTH-1:0][REG_ADDR_W-1:0] tag_rd,
  input  logic [FWD_DEPTH-1:0]                 tag_busy,
  output logic [SEL_W-1:0]                     sel,
  output logic                                 not_avail
);

  // Scan oldest to youngest so the youngest match overwrites older ones; an older pending
  // load is therefore masked by any younger writer of the same register.
  always_comb begin
    sel       = SEL_W'(FWD_SEL_REGFILE);
    not_avail = 1'b0;
    if (en && (src != '0)) begin
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (tag_valid[k] && (tag_rd[k] == src)) begin
          sel       = SEL_W'(fwd_stage_sel(unsigned'(k)));
          not_avail = tag_busy[k];
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard controller for the rv32i EX stage.
//
// Tracks destination registers of instructions that have left EX in a FWD_DEPTH-deep tag
// shift-register (stage 0 = EX/MEM, 1 = MEM/WB, 2 = WB staging) and derives per-source
// forward selects plus load-use / memory-wait stalls for the instruction currently in EX.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   ex_valid      valid instruction in EX
//   ex_rs_s       source specifiers, source i at [i*REG_ADDR_W +: REG_ADDR_W]
//   ex_rd_s       destination specifier
//   ex_regf_we    instruction writes the regfile
//   ex_is_load    instruction is a load
//   flush         kill the EX instruction
//   mem_wait      dmem response outstanding; freezes the tracker
//   fwd_sel       per source: 0 = regfile, k+1 = tracked stage k
//   stall         hold PC, IF/ID and ID/EX
//   bubble        insert an invalid entry into stage 0 (load-use)
//
// Optional (macro HAZ_PERF_CNT_EN):
//   perf_stall_cnt  cycles with bubble=1
//   perf_fwd_cnt    unstalled valid cycles with at least one forwarded source
module fwd_hazard_unit
  import rv32i_types::*;
#(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_DEPTH  = 3,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ex_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs_s,
  input  logic [REG_ADDR_W-1:0]         ex_rd_s,
  input  logic                          ex_regf_we,
  input  logic                          ex_is_load,
  input  logic                          flush,
  input  logic                          mem_wait,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          stall,
  output logic                          bubble
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_stall_cnt,
  output logic [31:0]                   perf_fwd_cnt
`endif
);

  // LOAD_LAT=0 still gets a 1-bit counter that simply never leaves 0.
  localparam int unsigned CNT_W = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;

  logic [FWD_DEPTH-1:0]                 valid_q, valid_d;
  logic [FWD_DEPTH-1:0][REG_ADDR_W-1:0] rd_q, rd_d;
  logic [FWD_DEPTH-1:0][CNT_W-1:0]      cnt_q, cnt_d;
  logic [FWD_DEPTH-1:0]                 busy;
  logic [NUM_SRC-1:0]                   src_not_avail;
  logic                                 hazard;
  logic                                 insert;

  always_comb begin
    busy = '0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      busy[k] = (cnt_q[k] != '0);
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .FWD_DEPTH (FWD_DEPTH),
      .REG_ADDR_W(REG_ADDR_W),
      .SEL_W     (SEL_W)
    ) u_match (
      .src      (ex_rs_s[i*REG_ADDR_W +: REG_ADDR_W]),
      .en       (ex_valid),
      .tag_valid(valid_q),
      .tag_rd   (rd_q),
      .tag_busy (busy),
      .sel      (fwd_sel[i*SEL_W +: SEL_W]),
      .not_avail(src_not_avail[i])
    );
  end

  // A flushed instruction never needs its operands, so a flush suppresses the load-use bubble.
  always_comb begin
    hazard = ex_valid & (|src_not_avail);
    bubble = hazard & ~mem_wait & ~flush;
    stall  = mem_wait | bubble;
    insert = ex_valid & ex_regf_we & ~bubble & ~flush & (ex_rd_s != '0);
  end

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (!mem_wait) begin
      for (int k = 1; k < FWD_DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        rd_d[k]    = rd_q[k-1];
        cnt_d[k]   = (cnt_q[k-1] != '0) ? cnt_q[k-1] - CNT_W'(1) : '0;
      end
      valid_d[0] = insert;
      rd_d[0]    = insert ? ex_rd_s : '0;
      cnt_d[0]   = (insert && ex_is_load) ? CNT_W'(LOAD_LAT) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (bubble) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (!stall && ex_valid && (fwd_sel != '0)) begin
        perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  localparam int NUM_SRC    = 2;
  localparam int FWD_DEPTH  = 3;
  localparam int REG_ADDR_W = 5;
  localparam int LOAD_LAT   = 1;
  localparam int SEL_W      = 2;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic                          ex_valid = 1'b0;
  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs_s = '0;
  logic [REG_ADDR_W-1:0]         ex_rd_s = '0;
  logic                          ex_regf_we = 1'b0;
  logic                          ex_is_load = 1'b0;
  logic                          flush = 1'b0;
  logic                          mem_wait = 1'b0;
  logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
  logic                          stall;
  logic                          bubble;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]                   perf_stall_cnt;
  logic [31:0]                   perf_fwd_cnt;
`endif

  fwd_hazard_unit #(
    .NUM_SRC   (NUM_SRC),
    .FWD_DEPTH (FWD_DEPTH),
    .REG_ADDR_W(REG_ADDR_W),
    .LOAD_LAT  (LOAD_LAT),
    .SEL_W     (SEL_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_rs_s       (ex_rs_s),
    .ex_rd_s       (ex_rd_s),
    .ex_regf_we    (ex_regf_we),
    .ex_is_load    (ex_is_load),
    .flush         (flush),
    .mem_wait      (mem_wait),
    .fwd_sel       (fwd_sel),
    .stall         (stall),
    .bubble        (bubble)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_fwd_cnt  (perf_fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       we, ld, fl, mw;
    logic [1:0] e0, e1;
    logic       es, eb;
  } vec_t;

  vec_t tbl[$];

  // Reference model: list of in-flight writers, youngest first, cycles until load data usable.
  typedef struct {
    bit v;
    int rd;
    int rem;
  } ent_t;

  ent_t pipe[$];
  int   m_stall_cnt;
  int   m_fwd_cnt;

  function automatic void add(input logic v, input int rs1, input int rs2, input int rd,
                              input logic we, input logic ld, input logic fl, input logic mw,
                              input int e0, input int e1, input logic es, input logic eb);
    vec_t t;
    t.v = v; t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rd = 5'(rd);
    t.we = we; t.ld = ld; t.fl = fl; t.mw = mw;
    t.e0 = 2'(e0); t.e1 = 2'(e1); t.es = es; t.eb = eb;
    tbl.push_back(t);
  endfunction

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we, input logic ld, input logic fl,
                       input logic mw);
    ex_valid = v; ex_rs_s = {rs2, rs1}; ex_rd_s = rd;
    ex_regf_we = we; ex_is_load = ld; flush = fl; mem_wait = mw;
  endtask

  task automatic cmp_outs(input string tag, input logic [1:0] e0, input logic [1:0] e1,
                          input logic es, input logic eb);
    logic [NUM_SRC*SEL_W-1:0] exp_sel;
    exp_sel = {e1, e0};
    n_vec++;
    if (fwd_sel !== exp_sel || stall !== es || bubble !== eb) begin
      n_bad++;
      $display("FAIL %s: got sel=%h stall=%b bubble=%b, want sel=%h stall=%b bubble=%b",
               tag, fwd_sel, stall, bubble, exp_sel, es, eb);
    end
  endtask

  task automatic cmp_cnt(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    for (int k = 0; k < FWD_DEPTH; k++) pipe.push_back('{v: 1'b0, rd: 0, rem: 0});
    m_stall_cnt = 0;
    m_fwd_cnt   = 0;
  endtask

  task automatic model_eval(input int rs1, input int rs2, input logic v,
                            output int s0, output int s1, output bit hz);
    int rs[2];
    int sel[2];
    rs[0] = rs1; rs[1] = rs2;
    hz = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sel[i] = 0;
      if (v && rs[i] != 0) begin
        for (int k = 0; k < FWD_DEPTH; k++) begin
          if (pipe[k].v && pipe[k].rd == rs[i]) begin
            sel[i] = k + 1;
            if (pipe[k].rem > 0) hz = 1'b1;
            break;
          end
        end
      end
    end
    s0 = sel[0]; s1 = sel[1];
  endtask

  task automatic model_advance(input logic v, input int rd, input logic we, input logic ld,
                               input logic fl, input logic bb);
    ent_t n;
    foreach (pipe[k]) if (pipe[k].rem > 0) pipe[k].rem--;
    n.v   = v && we && !bb && !fl && rd != 0;
    n.rd  = rd;
    n.rem = ld ? LOAD_LAT : 0;
    pipe.push_front(n);
    pipe = pipe[0:FWD_DEPTH-1];
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_bub;
    int exp_fwd;

    // Stimulus table; state follows from applying entries in order after reset.
    //   v rs1 rs2 rd we ld fl mw  e0 e1 es eb
    add(0,  0,  0,  0, 0, 0, 0, 0,  0, 0, 0, 0);  // reset state
    add(1,  1,  2,  5, 1, 0, 0, 0,  0, 0, 0, 0);  // add x5
    add(1,  5,  0,  6, 1, 0, 0, 0,  1, 0, 0, 0);  // uses x5 from EX/MEM
    add(1,  5,  6,  8, 1, 0, 0, 0,  2, 1, 0, 0);  // x5 now MEM/WB
    add(1,  1,  0,  7, 1, 1, 0, 0,  0, 0, 0, 0);  // lw x7
    add(1,  0,  7,  9, 1, 0, 0, 0,  0, 1, 1, 1);  // load-use
    add(1,  0,  7,  9, 1, 0, 0, 0,  0, 2, 0, 0);  // replay after bubble
    add(1,  0,  9,  0, 1, 0, 0, 0,  0, 1, 0, 0);  // writes x0
    add(1,  0,  9,  3, 1, 0, 0, 0,  0, 2, 0, 0);  // reads x0, x3 writer
    add(1,  0,  0,  3, 1, 0, 0, 0,  0, 0, 0, 0);  // second x3 writer
    add(1,  3,  3, 10, 1, 0, 0, 0,  1, 1, 0, 0);  // youngest x3 wins
    add(1,  0,  0,  4, 1, 1, 0, 0,  0, 0, 0, 0);  // lw x4
    add(1,  4,  3, 11, 1, 0, 1, 0,  1, 3, 0, 0);  // flush during load-use
    add(1, 11,  4,  0, 1, 0, 0, 0,  0, 2, 0, 0);  // killed x11 absent
    add(1,  0,  0, 12, 1, 0, 0, 0,  0, 0, 0, 0);  // add x12
    for (int r = 0; r < 4; r++) add(1, 12, 0, 13, 1, 0, 0, 1, 1, 0, 1, 0);  // frozen
    add(1, 12,  0, 13, 1, 0, 0, 0,  1, 0, 0, 0);  // release
    add(1, 12, 13,  0, 1, 0, 0, 0,  2, 1, 0, 0);
    add(1, 12, 13,  0, 1, 0, 0, 0,  3, 2, 0, 0);
    add(1, 12, 13,  0, 0, 0, 0, 0,  0, 3, 0, 0);  // x12 dropped out
    add(1,  0,  0, 14, 1, 1, 0, 0,  0, 0, 0, 0);  // lw x14
    add(1, 14,  0,  0, 1, 0, 0, 1,  1, 0, 1, 0);  // mem_wait masks bubble
    add(1, 14,  0,  0, 1, 0, 0, 0,  1, 0, 1, 1);  // load-use after release
    add(1, 14,  0,  0, 1, 0, 0, 0,  2, 0, 0, 0);
    add(1, 14,  0, 15, 1, 0, 1, 1,  3, 0, 1, 0);  // freeze beats flush
    add(1, 14, 15,  0, 1, 0, 0, 0,  3, 0, 0, 0);  // state was held

    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    exp_bub = 0;
    exp_fwd = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].we, tbl[i].ld, tbl[i].fl,
            tbl[i].mw);
      @(negedge clk);
      cmp_outs($sformatf("tbl[%0d]", i), tbl[i].e0, tbl[i].e1, tbl[i].es, tbl[i].eb);
      if (tbl[i].eb) exp_bub++;
      if (!tbl[i].es && tbl[i].v && (tbl[i].e0 != 0 || tbl[i].e1 != 0)) exp_fwd++;
      @(posedge clk);
      #1;
    end
`ifdef HAZ_PERF_CNT_EN
    cmp_cnt("tbl_perf_stall", perf_stall_cnt, 32'(exp_bub));
    cmp_cnt("tbl_perf_fwd", perf_fwd_cnt, 32'(exp_fwd));
`endif

    // Randomized traffic against the reference model.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic v, we, ld, fl, mw;
      int   rs1, rs2, rd, s0, s1;
      bit   hz, bb, st;
      v   = ($urandom_range(0, 9) < 8);
      we  = ($urandom_range(0, 9) < 8);
      ld  = ($urandom_range(0, 9) < 4);
      fl  = ($urandom_range(0, 9) < 1);
      mw  = ($urandom_range(0, 9) < 2);
      rs1 = $urandom_range(0, 7);
      rs2 = $urandom_range(0, 7);
      rd  = $urandom_range(0, 7);
      drive(v, 5'(rs1), 5'(rs2), 5'(rd), we, ld, fl, mw);
      model_eval(rs1, rs2, v, s0, s1, hz);
      bb = hz && !mw && !fl;
      st = mw || bb;
      @(negedge clk);
      cmp_outs($sformatf("rand[%0d]", c), 2'(s0), 2'(s1), st, bb);
      if (bb) m_stall_cnt++;
      if (!st && v && (s0 != 0 || s1 != 0)) m_fwd_cnt++;
      if (!mw) model_advance(v, rd, we, ld, fl, bb);
      @(posedge clk);
      #1;
    end
`ifdef HAZ_PERF_CNT_EN
    cmp_cnt("rand_perf_stall", perf_stall_cnt, 32'(m_stall_cnt));
    cmp_cnt("rand_perf_fwd", perf_fwd_cnt, 32'(m_fwd_cnt));
`endif

    // Async reset mid-stream: load x21 in flight, reader stalled, then reset between edges.
    drive(1, 0, 0, 21, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    drive(1, 21, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    cmp_outs("pre_reset", 2'd1, 2'd0, 1'b1, 1'b1);
    #1 rst = 1'b1;
    #1;
    cmp_outs("async_reset", 2'd0, 2'd0, 1'b0, 1'b0);
`ifdef HAZ_PERF_CNT_EN
    cmp_cnt("reset_perf_stall", perf_stall_cnt, 32'd0);
    cmp_cnt("reset_perf_fwd", perf_fwd_cnt, 32'd0);
`endif
    #1 rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
